// File: rtl/extensor_inmediato_pipe_pkg.sv
// Shared types and defaults for the pipelined immediate extender.
package extensor_pkg;

    localparam int IN_W_DEF  = 16;
    localparam int OUT_W_DEF = 32;
    localparam int TAG_W_DEF = 5;

    // Extension mode carried with every immediate.
    typedef enum logic [1:0] {
        MODE_ZERO      = 2'b00,
        MODE_SIGN      = 2'b01,
        MODE_UPPER     = 2'b10,
        MODE_SIGN_SHL2 = 2'b11
    } mode_e;

    // Occupancy of the OUT/SKID pair; bit 0 = OUT valid, bit 1 = SKID valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } occ_state_e;

endpackage

// File: rtl/extensor_inmediato_pipe_if.sv
// Bus bundle for the immediate extender: upstream request side plus
// downstream operand side.
//
// Handshake: on each side a transfer happens on a rising clk edge where
// valid && ready are both high. ready never depends on valid. A producer may
// change its payload while valid && !ready; only the payload present on the
// transfer edge is taken. The stage holds out_data/out_tag stable while
// out_valid && !out_ready.
interface extensor_inmediato_pipe_if
    import extensor_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int TAG_W = TAG_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    mode_e            in_mode;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    // Environment side: produces immediates, consumes operands.
    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    // Stage side.
    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/extensor_inmediato_pipe_nucleo.sv
// Purely combinational immediate extension (zero, sign, upper, sign<<2).
// OUT_W must exceed IN_W; IN_W must be at least 1.
module extensor_nucleo
    import extensor_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [IN_W-1:0]  imm,
    input  mode_e            mode,
    output logic [OUT_W-1:0] data
);
    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;

    assign sext = {{PAD_W{imm[IN_W-1]}}, imm};

    // Select the extension; the shifted form drops bits above OUT_W.
    always_comb begin
        data = '0;
        case (mode)
            MODE_ZERO:      data = {{PAD_W{1'b0}}, imm};
            MODE_SIGN:      data = sext;
            MODE_UPPER:     data = {imm, {PAD_W{1'b0}}};
            MODE_SIGN_SHL2: data = sext << 2;
            default:        data = '0;
        endcase
    end
endmodule

// File: rtl/extensor_inmediato_pipe.sv
// Pipelined immediate extension stage: extends on acceptance, then holds the
// operand in an OUT register backed by one SKID register so downstream
// back-pressure never drops or reorders operands.
module extensor_inmediato_pipe
    import extensor_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    extensor_inmediato_pipe_if.slave   bus,
    output occ_state_e                 dbg_state
);
    logic [OUT_W-1:0] ext_data;

    occ_state_e       state_q;
    occ_state_e       state_d;
    logic [OUT_W-1:0] out_data_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [OUT_W-1:0] skid_data_q;
    logic [TAG_W-1:0] skid_tag_q;

    logic acc;
    logic pop;
    logic load_out_in;
    logic load_out_skid;
    logic load_skid;

    extensor_nucleo #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_nucleo (
        .imm  (bus.in_imm),
        .mode (bus.in_mode),
        .data (ext_data)
    );

    // in_ready only looks at the SKID valid bit, so it never combinationally
    // follows in_valid or out_ready; it is forced low while in reset.
    assign bus.in_ready  = rst_n && !state_q[1];
    assign bus.out_valid = state_q[0];
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;
    assign dbg_state     = state_q;

    assign acc = bus.in_valid && bus.in_ready;
    assign pop = bus.out_valid && bus.out_ready;

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy and register load controls.
    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d     = ST_ONE;
                    load_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (acc && pop) begin
                    load_out_in = 1'b1;
                end else if (acc) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    state_d       = ST_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // OUT register: loaded from the extender or promoted from SKID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else if (load_out_in) begin
            out_data_q <= ext_data;
            out_tag_q  <= bus.in_tag;
        end else if (load_out_skid) begin
            out_data_q <= skid_data_q;
            out_tag_q  <= skid_tag_q;
        end
    end

    // SKID register: catches the item accepted while OUT is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else if (load_skid) begin
            skid_data_q <= ext_data;
            skid_tag_q  <= bus.in_tag;
        end
    end
endmodule

// File: tb/tb_extensor_inmediato_pipe.sv
// Directed bench for extensor_inmediato_pipe (16->32 and 31->32 instances).
module tb_extensor_inmediato_pipe;
    import extensor_pkg::*;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    logic [36:0] exp_q[$];
    logic        sb_on = 1'b0;
    int          n_push = 0;
    int          n_pop = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [4:0]  prev_tag;

    occ_state_e a_state;
    occ_state_e b_state;

    extensor_inmediato_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) a_if ();
    extensor_inmediato_pipe_if #(.IN_W(31), .OUT_W(32), .TAG_W(5)) b_if ();

    extensor_inmediato_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (a_if),
        .dbg_state (a_state)
    );

    extensor_inmediato_pipe #(.IN_W(31), .OUT_W(32), .TAG_W(5)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (b_if),
        .dbg_state (b_state)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference extension for the 16->32 instance.
    function automatic logic [31:0] model16(input logic [15:0] imm, input logic [1:0] m);
        case (m)
            2'b00:   return {16'h0000, imm};
            2'b01:   return imm[15] ? {16'hFFFF, imm} : {16'h0000, imm};
            2'b10:   return {imm, 16'h0000};
            default: return {{14{imm[15]}}, imm, 2'b00};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [15:0] imm, input mode_e m, input logic [4:0] tag);
        a_if.in_valid = v;
        a_if.in_imm   = imm;
        a_if.in_mode  = m;
        a_if.in_tag   = tag;
    endtask

    task automatic drive_b(input logic v, input logic [30:0] imm, input mode_e m, input logic [4:0] tag);
        b_if.in_valid = v;
        b_if.in_imm   = imm;
        b_if.in_mode  = m;
        b_if.in_tag   = tag;
    endtask

    // Scoreboard: sampled mid-cycle, ahead of the edge that performs the transfers.
    always @(negedge clk) begin
        if (sb_on && rst_n) begin
            if (prev_stall) begin
                check("stable_data", a_if.out_data, prev_data);
                check("stable_tag", a_if.out_tag, prev_tag);
            end
            prev_stall = a_if.out_valid && !a_if.out_ready;
            prev_data  = a_if.out_data;
            prev_tag   = a_if.out_tag;
            if (a_if.out_valid && a_if.out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    check("sb_item", {a_if.out_tag, a_if.out_data}, exp_q.pop_front());
                end
            end
            if (a_if.in_valid && a_if.in_ready) begin
                n_push++;
                exp_q.push_back({a_if.in_tag, model16(a_if.in_imm, a_if.in_mode)});
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Directed sequence.
    initial begin
        int n_acc;
        int cyc;
        rst_n = 1'b0;
        drive_a(1'b0, 16'h0, MODE_ZERO, 5'd0);
        drive_b(1'b0, 31'h0, MODE_ZERO, 5'd0);
        a_if.out_ready = 1'b0;
        b_if.out_ready = 1'b0;

        // Reset values.
        #1;
        check("rst_out_valid", a_if.out_valid, 0);
        check("rst_out_data", a_if.out_data, 0);
        check("rst_out_tag", a_if.out_tag, 0);
        check("rst_in_ready", a_if.in_ready, 0);
        check("rst_state", a_state, ST_EMPTY);
        step();
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", a_if.in_ready, 1);

        // Mode sweep, back-to-back with out_ready high.
        step();
        a_if.out_ready = 1'b1;
        drive_a(1'b1, 16'h8001, MODE_ZERO, 5'd1);
        step();
        check("sw_zero_data", a_if.out_data, 32'h00008001);
        check("sw_zero_tag", a_if.out_tag, 5'd1);
        drive_a(1'b1, 16'h8001, MODE_SIGN, 5'd2);
        step();
        check("sw_sign_data", a_if.out_data, 32'hFFFF8001);
        check("sw_sign_tag", a_if.out_tag, 5'd2);
        drive_a(1'b1, 16'h1234, MODE_UPPER, 5'd3);
        step();
        check("sw_upper_data", a_if.out_data, 32'h12340000);
        check("sw_upper_tag", a_if.out_tag, 5'd3);
        drive_a(1'b1, 16'hFFFF, MODE_SIGN_SHL2, 5'd4);
        step();
        check("sw_shl2n_data", a_if.out_data, 32'hFFFFFFFC);
        check("sw_shl2n_tag", a_if.out_tag, 5'd4);
        drive_a(1'b1, 16'h0004, MODE_SIGN_SHL2, 5'd5);
        step();
        check("sw_shl2p_data", a_if.out_data, 32'h00000010);
        check("sw_shl2p_tag", a_if.out_tag, 5'd5);
        check("sw_valid", a_if.out_valid, 1);
        drive_a(1'b0, 16'h0, MODE_ZERO, 5'd0);
        step();
        check("sw_drain", a_if.out_valid, 0);

        // Back-pressure: tags 1,2 accepted, 3 stalls.
        a_if.out_ready = 1'b0;
        drive_a(1'b1, 16'h0001, MODE_ZERO, 5'd1);
        step();
        check("bp_t1_tag", a_if.out_tag, 5'd1);
        check("bp_t1_ready", a_if.in_ready, 1);
        drive_a(1'b1, 16'h0002, MODE_ZERO, 5'd2);
        step();
        check("bp_t2_ready", a_if.in_ready, 0);
        check("bp_t2_state", a_state, ST_TWO);
        check("bp_t2_tag", a_if.out_tag, 5'd1);
        drive_a(1'b1, 16'h00AA, MODE_UPPER, 5'd3);
        step();
        check("bp_stall_ready", a_if.in_ready, 0);
        check("bp_stall_data", a_if.out_data, 32'h00000001);
        drive_a(1'b1, 16'h0003, MODE_ZERO, 5'd3);
        a_if.out_ready = 1'b1;
        step();
        check("bp_o2_tag", a_if.out_tag, 5'd2);
        check("bp_o2_ready", a_if.in_ready, 1);
        step();
        drive_a(1'b0, 16'h0, MODE_ZERO, 5'd0);
        check("bp_o3_tag", a_if.out_tag, 5'd3);
        check("bp_o3_data", a_if.out_data, 32'h00000003);
        step();
        check("bp_empty", a_if.out_valid, 0);
        check("bp_ready_back", a_if.in_ready, 1);

        // Streaming: 100 back-to-back items.
        sb_on = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive_a(1'b1, 16'($urandom), mode_e'($urandom_range(0, 3)), 5'($urandom));
            step();
            check("st_no_bubble", a_if.out_valid, 1);
        end
        drive_a(1'b0, 16'h0, MODE_ZERO, 5'd0);
        step();
        step();
        check("st_drained", exp_q.size(), 0);

        // Random in_valid / out_ready over 1000 accepted items.
        n_acc = 0;
        cyc = 0;
        while (n_acc < 1000 && cyc < 20000) begin
            drive_a(1'($urandom_range(0, 1)), 16'($urandom), mode_e'($urandom_range(0, 3)), 5'($urandom));
            a_if.out_ready = 1'($urandom_range(0, 1));
            #0;
            if (a_if.in_valid && a_if.in_ready) n_acc++;
            step();
            cyc++;
        end
        check("rnd_accepted", n_acc, 1000);
        drive_a(1'b0, 16'h0, MODE_ZERO, 5'd0);
        a_if.out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 10) begin
            step();
            cyc++;
        end
        step();
        check("rnd_drained", exp_q.size(), 0);
        check("rnd_counts", n_pop, n_push);
        check("rnd_total", n_push, 1100);
        sb_on = 1'b0;

        // Asynchronous reset while holding two items.
        a_if.out_ready = 1'b0;
        drive_a(1'b1, 16'h1111, MODE_ZERO, 5'd7);
        step();
        drive_a(1'b1, 16'h2222, MODE_ZERO, 5'd8);
        step();
        drive_a(1'b0, 16'h0, MODE_ZERO, 5'd0);
        check("rs_two", a_state, ST_TWO);
        #3;
        rst_n = 1'b0;
        #1;
        check("rs_out_valid", a_if.out_valid, 0);
        check("rs_in_ready", a_if.in_ready, 0);
        check("rs_out_data", a_if.out_data, 0);
        check("rs_state", a_state, ST_EMPTY);
        step();
        check("rs_in_ready_hold", a_if.in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("rs_rel_ready", a_if.in_ready, 1);
        a_if.out_ready = 1'b1;
        drive_a(1'b1, 16'h00FF, MODE_ZERO, 5'd9);
        step();
        check("rs_new_data", a_if.out_data, 32'h000000FF);
        check("rs_new_tag", a_if.out_tag, 5'd9);
        drive_a(1'b0, 16'h0, MODE_ZERO, 5'd0);
        step();
        check("rs_drain", a_if.out_valid, 0);

        // 31->32 boundary instance.
        b_if.out_ready = 1'b1;
        drive_b(1'b1, 31'h40000000, MODE_SIGN, 5'd1);
        step();
        check("bd_sign", b_if.out_data, 32'hC0000000);
        drive_b(1'b1, 31'h40000000, MODE_SIGN_SHL2, 5'd2);
        step();
        check("bd_shl2", b_if.out_data, 32'h00000000);
        check("bd_tag", b_if.out_tag, 5'd2);
        drive_b(1'b1, 31'h00000001, MODE_UPPER, 5'd3);
        step();
        check("bd_upper", b_if.out_data, 32'h00000002);
        drive_b(1'b0, 31'h0, MODE_ZERO, 5'd0);
        step();

        // Final report.
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/extensor_inmediato_pipe.md
# extensor_inmediato_pipe

Parametrised, pipelined immediate-extension stage for the datapath between decode and execute. Each accepted transaction carries an IN_W-bit immediate, a 2-bit extension mode and a sideband tag, and produces an OUT_W-bit operand. The stage uses valid/ready handshakes on both sides and a two-entry skid buffer, so back-pressure from execute never drops or reorders operands. It generalises fixed 16→32 zero extension to four modes and arbitrary widths.

## Interface
- IN_W, 16, immediate input width; must be ≥ 1.
- OUT_W, 32, extended output width; must be > IN_W.
- TAG_W, 5, sideband tag width (e.g. destination register number); must be ≥ 1.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  upstream offers a transaction.
- in_ready  output  1  stage can accept; a transfer occurs when in_valid && in_ready.
- in_imm  input  IN_W  raw immediate.
- in_mode  input  2  extension mode (package enum).
- in_tag  input  TAG_W  sideband, passed through unmodified.
- out_valid  output  1  output operand valid.
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready.
- out_data  output  OUT_W  extended operand.
- out_tag  output  TAG_W  tag of the operand on out_data.

## Operation
- Modes, computed on input at acceptance:
  - MODE_ZERO (00): upper OUT_W-IN_W bits are 0.
  - MODE_SIGN (01): upper bits replicate in_imm[IN_W-1].
  - MODE_UPPER (10): in_imm placed in the top IN_W bits; the low OUT_W-IN_W bits are 0.
  - MODE_SIGN_SHL2 (11): sign-extend, then shift left by 2 and truncate to OUT_W bits (branch offsets).
- Storage: an output register (OUT) plus one skid register (SKID). Each holds {data, tag}.
- State machine, held as valid bits:
  - EMPTY: neither register is valid.
  - ONE: OUT is valid.
  - TWO: OUT and SKID are both valid.
- Transitions (acc = input transfer, pop = output transfer):
  - EMPTY + acc → ONE.
  - ONE + acc and no pop → TWO; the new item goes to SKID.
  - ONE + acc + pop → ONE; OUT is reloaded with the new item.
  - ONE + pop and no acc → EMPTY.
  - TWO + pop → ONE; SKID moves to OUT.
  - acc is impossible in TWO.
- in_ready = rst_n && !SKID valid. It is combinational from a register and never depends on in_valid or out_ready.
- out_valid = OUT valid. out_data and out_tag hold stable while out_valid && !out_ready.
- Order is strictly FIFO. No transaction is lost or duplicated.

## Timing
- Latency: 1 cycle. An item accepted at edge N is on out_data after edge N, when the stage was EMPTY or popping.
- Throughput: 1 transfer/cycle with out_ready held high.
- Reset (asynchronous, rst_n low):
  - out_valid = 0, out_data = 0, out_tag = 0.
  - SKID is cleared to invalid.
  - in_ready = 0 while rst_n is low; in_ready = 1 from the first cycle after release.
- Reset mid-operation: all in-flight items are discarded. No output transfer occurs on or after the asserting edge.
- Simultaneous acc + pop in ONE: the new item is visible on the next cycle with no bubble.
- Changing in_imm, in_mode or in_tag while in_valid && !in_ready has no effect on state.

## Structure
- Package extensor_pkg holds:
  - the mode enum: MODE_ZERO, MODE_SIGN, MODE_UPPER, MODE_SIGN_SHL2 (2 bits);
  - the parameter defaults IN_W_DEF = 16 and OUT_W_DEF = 32.
- Sub-module extensor_nucleo is the purely combinational extension (IN_W, OUT_W; imm, mode → data). It is instantiated once, on the input side, ahead of the skid logic.
- The top level contains only the handshake/skid state and the registers.

## Test plan
All scenarios use IN_W = 16, OUT_W = 32, TAG_W = 5.
- Mode sweep, out_ready = 1:
  - 0x8001 ZERO → 0x00008001;
  - 0x8001 SIGN → 0xFFFF8001;
  - 0x1234 UPPER → 0x12340000;
  - 0xFFFF SIGN_SHL2 → 0xFFFFFFFC;
  - 0x0004 SIGN_SHL2 → 0x00000010.
  - Each result appears 1 cycle after acceptance, with the matching tag.
- Back-pressure: hold out_ready = 0 and offer tags 1, 2, 3.
  - Tags 1 and 2 are accepted; in_ready falls the cycle after tag 2; tag 3 stalls.
  - Raise out_ready: the outputs are 1, 2, 3 in order and in_ready returns to 1.
- Streaming: 100 back-to-back items with random modes and out_ready = 1.
  - One output per cycle, no bubbles; out_data matches a reference model.
- Random out_ready (50 % duty) and random in_valid over 1000 items.
  - No loss, no duplication, order preserved.
  - out_data and out_tag are stable whenever out_valid && !out_ready.
- Reset in state TWO: assert rst_n low asynchronously, mid-cycle.
  - out_valid drops immediately and in_ready drops while rst_n is low.
  - After release, in_ready = 1 and the first new item (0x00FF ZERO) → 0x000000FF.
- Boundary parameters: IN_W = 31, OUT_W = 32.
  - SIGN 0x40000000 → 0xC0000000.
  - SIGN_SHL2 → 0x00000000 (truncation).
